// File: rtl/pbox_pipe.sv
// pbox_pipe: forward/inverse PRESENT-family bit permutation for any WIDTH that
// is a multiple of 4. The result is registered through STAGES elastic
// valid/ready stages. The wiring of the permutation is fixed at elaboration.
module pbox_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             busy
);

  localparam int N = WIDTH / 4;   // S-box count
  localparam int M = WIDTH - 1;   // modulus of the index map

  // Reject widths and depths that have no defined permutation or pipeline.
  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("pbox_pipe: WIDTH must be a multiple of 4 and at least 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pbox_pipe: STAGES must be in 1..4");
    end
  endgenerate

  // Permutation networks. Forward sends bit i to (i*n) mod M and inverse sends
  // it to (i*4) mod M. Because n*4 = WIDTH = M+1, the two maps undo each other.
  // The top bit is a fixed point in both directions.
  logic [WIDTH-1:0] fwd_perm;
  logic [WIDTH-1:0] inv_perm;
  logic [WIDTH-1:0] perm_data;

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_perm
      localparam int FWD_IDX = (gi * N) % M;
      localparam int INV_IDX = (gi * 4) % M;
      assign fwd_perm[FWD_IDX] = in_data[gi];
      assign inv_perm[INV_IDX] = in_data[gi];
    end
  endgenerate

  assign fwd_perm[M] = in_data[M];
  assign inv_perm[M] = in_data[M];
  assign perm_data   = in_mode ? inv_perm : fwd_perm;

  // Pipeline stage state.
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] mode_reg;
  logic [WIDTH-1:0]  data_reg [STAGES];

  // Per-stage source: stage 0 takes the permuted input, and every later stage
  // takes its predecessor.
  logic [STAGES-1:0] feed_valid;
  logic [STAGES-1:0] feed_mode;
  logic [WIDTH-1:0]  feed_data [STAGES];

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_feed
      if (gi == 0) begin : g_first
        assign feed_valid[gi] = in_valid;
        assign feed_mode[gi]  = in_mode;
        assign feed_data[gi]  = perm_data;
      end else begin : g_next
        assign feed_valid[gi] = valid_reg[gi-1];
        assign feed_mode[gi]  = mode_reg[gi-1];
        assign feed_data[gi]  = data_reg[gi-1];
      end
    end
  endgenerate

  // Ready ripples back from the output. A stage can load when it is empty or
  // when its contents move on this cycle, so bubbles collapse.
  logic [STAGES:0] stage_ready;

  // Ready chain, evaluated from the output stage down to the input stage.
  always_comb begin
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_reg[k] || stage_ready[k+1];
    end
  end

  // Stage registers: advance where ready is set. Data and mode are only
  // captured for valid words, and stalled stages hold their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      mode_reg  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          valid_reg[k] <= feed_valid[k];
          if (feed_valid[k]) begin
            mode_reg[k] <= feed_mode[k];
            data_reg[k] <= feed_data[k];
          end
        end
      end
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_reg[STAGES-1];
  assign out_mode  = mode_reg[STAGES-1];
  assign out_data  = data_reg[STAGES-1];
  assign busy      = |valid_reg;

endmodule

// File: tb/tb_pbox_pipe.sv
// tb_pbox_pipe: directed and random checks of pbox_pipe across several
// WIDTH/STAGES configurations, using a scoreboard of reference permutations.
module tb_pbox_pipe;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: WIDTH=64 STAGES=1 ; b: 64/2 ; c: 64/3 ; d: 64/4 ; e: 32/1 ; f: 16/1
  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode, a_busy;
  logic [63:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_busy;
  logic [63:0] b_in_data, b_out_data;
  logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_mode, c_busy;
  logic [63:0] c_in_data, c_out_data;
  logic        d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_mode, d_busy;
  logic [63:0] d_in_data, d_out_data;
  logic        e_in_valid, e_in_ready, e_in_mode, e_out_valid, e_out_ready, e_out_mode, e_busy;
  logic [31:0] e_in_data, e_out_data;
  logic        f_in_valid, f_in_ready, f_in_mode, f_out_valid, f_out_ready, f_out_mode, f_busy;
  logic [15:0] f_in_data, f_out_data;

  pbox_pipe #(.WIDTH(64), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode), .busy(a_busy));
  pbox_pipe #(.WIDTH(64), .STAGES(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_mode(b_out_mode), .busy(b_busy));
  pbox_pipe #(.WIDTH(64), .STAGES(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(c_in_mode),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_mode(c_out_mode), .busy(c_busy));
  pbox_pipe #(.WIDTH(64), .STAGES(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_mode(d_in_mode),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_mode(d_out_mode), .busy(d_busy));
  pbox_pipe #(.WIDTH(32), .STAGES(1)) u_e (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_mode(e_in_mode),
    .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_data(e_out_data), .out_mode(e_out_mode), .busy(e_busy));
  pbox_pipe #(.WIDTH(16), .STAGES(1)) u_f (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_mode(f_in_mode),
    .in_data(f_in_data), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_data(f_out_data), .out_mode(f_out_mode), .busy(f_busy));

  // Reference permutation taken directly from the index rule.
  function automatic logic [63:0] pmodel(input logic [63:0] x, input int w, input bit inv);
    logic [63:0] r;
    int m;
    int step;
    r    = '0;
    m    = w - 1;
    step = inv ? 4 : w / 4;
    for (int i = 0; i < m; i++) r[(i * step) % m] = x[i];
    r[m] = x[m];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef logic [64:0] q_t [$];
  q_t qb, qc, qd;
  int em_b, em_c, em_d;
  bit acc_b, acc_c, acc_d;

  // Scoreboard step for one pipelined instance, evaluated just before an edge.
  task automatic sb(ref q_t q, input string tag, input logic iv, input logic ir, input logic im,
                    input logic [63:0] id, input logic ov, input logic orr, input logic om,
                    input logic [63:0] od, output bit acc, ref int em);
    logic [64:0] e;
    acc = iv && ir;
    if (ov && orr) begin
      em++;
      chk({tag, "_nonempty"}, 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({tag, "_data"}, od, e[63:0]);
        chk({tag, "_mode"}, 64'(om), 64'(e[64]));
      end
    end
    if (acc) q.push_back({im, pmodel(id, 64, im)});
  endtask

  // One clock: settle, update scoreboards, cross the edge, sample point +1.
  task automatic tick();
    #1;
    if (rst) begin
      qb.delete(); qc.delete(); qd.delete();
      acc_b = 0; acc_c = 0; acc_d = 0;
    end else begin
      sb(qb, "b", b_in_valid, b_in_ready, b_in_mode, b_in_data, b_out_valid, b_out_ready,
         b_out_mode, b_out_data, acc_b, em_b);
      sb(qc, "c", c_in_valid, c_in_ready, c_in_mode, c_in_data, c_out_valid, c_out_ready,
         c_out_mode, c_out_data, acc_c, em_c);
      sb(qd, "d", d_in_valid, d_in_ready, d_in_mode, d_in_data, d_out_valid, d_out_ready,
         d_out_mode, d_out_data, acc_d, em_d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [63:0] x, input logic m, input logic [63:0] exp, input string tag);
    a_in_valid = 1'b1;
    a_in_mode  = m;
    a_in_data  = x;
    tick();
    a_in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_data"}, a_out_data, exp);
    chk({tag, "_mode"}, 64'(a_out_mode), 64'(m));
  endtask

  initial begin
    logic [63:0] x, y, held;
    int n_acc, em_snap, acc_total;
    tests = 0; fails = 0; em_b = 0; em_c = 0; em_d = 0;
    rst = 1'b1;
    {a_in_valid, a_in_mode, a_out_ready} = '0; a_in_data = '0;
    {b_in_valid, b_in_mode, b_out_ready} = '0; b_in_data = '0;
    {c_in_valid, c_in_mode, c_out_ready} = '0; c_in_data = '0;
    {d_in_valid, d_in_mode, d_out_ready} = '0; d_in_data = '0;
    {e_in_valid, e_in_mode, e_out_ready} = '0; e_in_data = '0;
    {f_in_valid, f_in_mode, f_out_ready} = '0; f_in_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", a_out_data, 64'd0);
    chk("rst_out_mode", 64'(a_out_mode), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_in_ready_d", 64'(d_in_ready), 64'd1);

    // WIDTH=64 STAGES=1 directed vectors
    a_out_ready = 1'b1;
    send_a(64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0001_0000, "fwd_bit1");
    send_a(64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, "fwd_bit0");
    send_a(64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, "fwd_bit63");
    send_a(64'h0000_0000_0000_0002, 1'b1, 64'h0000_0000_0000_0010, "inv_bit1");
    send_a(64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0002, "inv_bit16");

    // Random round trips: forward result from the DUT fed back through inverse
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      send_a(x, 1'b0, pmodel(x, 64, 1'b0), "rt_fwd");
      y = a_out_data;
      send_a(y, 1'b1, x, "rt_inv");
    end

    // Narrow widths
    e_out_ready = 1'b1; e_in_valid = 1'b1; e_in_data = 32'h2; e_in_mode = 1'b0;
    tick();
    chk("w32_fwd", 64'(e_out_data), 64'h100);
    e_in_mode = 1'b1;
    tick();
    chk("w32_inv", 64'(e_out_data), 64'h10);
    e_in_valid = 1'b0;
    f_out_ready = 1'b1; f_in_valid = 1'b1; f_in_data = 16'h2; f_in_mode = 1'b0;
    tick();
    chk("w16_fwd", 64'(f_out_data), 64'h10);
    f_in_mode = 1'b1;
    tick();
    chk("w16_inv", 64'(f_out_data), 64'h10);
    for (int i = 0; i < 8; i++) begin
      f_in_data = 16'($urandom);
      f_in_mode = 1'($urandom);
      x = 64'(f_in_data);
      tick();
      chk("w16_involution", 64'(f_out_data), pmodel(x, 16, 1'b0));
    end
    f_in_valid = 1'b0;

    // STAGES=3 back-to-back stream of 10 words with alternating mode
    c_out_ready = 1'b1;
    em_snap = em_c;
    for (int t = 1; t <= 13; t++) begin
      if (t <= 10) begin
        c_in_valid = 1'b1;
        c_in_mode  = 1'((t - 1) % 2);
        c_in_data  = {$urandom, $urandom};
      end else begin
        c_in_valid = 1'b0;
      end
      tick();
      if (t <= 10) chk("c_accept", 64'(acc_c), 64'd1);
      if (t <= 12) chk("c_out_valid", 64'(c_out_valid), 64'(t >= 3));
    end
    chk("c_busy_drop", 64'(c_busy), 64'd0);
    chk("c_emits", 64'(em_c - em_snap), 64'd10);

    // STAGES=2 backpressure
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = {$urandom, $urandom}; b_in_mode = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (acc_b) begin
        n_acc++;
        b_in_data = {$urandom, $urandom};
        b_in_mode = ~b_in_mode;
      end
    end
    #1;
    chk("b_accepts", 64'(n_acc), 64'd2);
    chk("b_in_ready_low", 64'(b_in_ready), 64'd0);
    held = b_out_data;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("b_hold_data", b_out_data, held);
      chk("b_hold_valid", 64'(b_out_valid), 64'd1);
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    #1;
    chk("b_in_ready_comb", 64'(b_in_ready), 64'd1);
    for (int t = 0; t < 4; t++) tick();
    chk("b_drain_count", 64'(em_b), 64'd2);
    chk("b_drain_empty", 64'(qb.size()), 64'd0);

    // STAGES=4 fill, then reset mid-stream
    d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_mode = 1'b1;
    n_acc = 0;
    for (int t = 0; t < 6; t++) begin
      d_in_data = {$urandom, $urandom};
      tick();
      if (acc_d) n_acc++;
    end
    chk("d_fill_accepts", 64'(n_acc), 64'd4);
    chk("d_fill_busy", 64'(d_busy), 64'd1);
    rst = 1'b1; d_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("d_rst_out_valid", 64'(d_out_valid), 64'd0);
    chk("d_rst_out_data", d_out_data, 64'd0);
    chk("d_rst_busy", 64'(d_busy), 64'd0);
    chk("d_rst_in_ready", 64'(d_in_ready), 64'd1);
    d_out_ready = 1'b1;
    em_snap = em_d;
    for (int t = 0; t < 6; t++) tick();
    chk("d_no_stale_emit", 64'(em_d - em_snap), 64'd0);
    d_in_valid = 1'b1; d_in_mode = 1'b0; d_in_data = {$urandom, $urandom};
    tick();
    d_in_valid = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    chk("d_post_rst_emit", 64'(em_d - em_snap), 64'd1);

    // Random traffic with random backpressure on STAGES=3
    em_snap = em_c;
    acc_total = 0;
    for (int t = 0; t < 400; t++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_in_mode   = 1'($urandom_range(0, 1));
      c_in_data   = {$urandom, $urandom};
      c_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_c) acc_total++;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    chk("c_rand_empty", 64'(qc.size()), 64'd0);
    chk("c_rand_count", 64'(em_c - em_snap), 64'(acc_total));
    chk("c_rand_busy", 64'(c_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
